// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: grants one requester at a time,
// drives the mux select lines and limits each grant to MAX_HOLD cycles.
module mux41_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel1,
    output logic       sel0,
    output logic       valid,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;     // current owner while in GRANT
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic       rearb;

    // Search starts one past the last owner, so the previous owner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        idx       = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        rearb     = 1'b0;

        case (state_q)
            IDLE: rearb = win_found;
            GRANT: begin
                if (!req[last_q]) begin
                    rearb = 1'b1;
                end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                    rearb     = 1'b1;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Release and re-grant happen on the same edge, so handoffs have no bubble.
        if (rearb) begin
            if (win_found) begin
                state_d = GRANT;
                last_d  = win_idx;
                cnt_d   = CNT_W'(1);
                gnt_d   = 4'b0001 << win_idx;
                sel_d   = win_idx;
                valid_d = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel1    = sel_q[1];
    assign sel0    = sel_q[0];
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Drives three arbiters (MAX_HOLD 4, 2, 1) with shared directed and random
// request patterns and compares each against a behavioural reference model.
module tb_mux41_rr_arbiter;

    localparam int NDUT = 3;
    localparam int HOLDS [NDUT] = '{4, 2, 1};

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_o     [NDUT];
    logic       sel1_o    [NDUT];
    logic       sel0_o    [NDUT];
    logic       valid_o   [NDUT];
    logic       preempt_o [NDUT];

    int checks = 0;
    int errors = 0;

    // Reference model: owner = -1 when idle.
    int m_owner [NDUT];
    int m_held  [NDUT];
    int m_last  [NDUT];
    int m_sel   [NDUT];
    int m_pre   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mux41_rr_arbiter #(.MAX_HOLD(HOLDS[g]), .CNT_W(8)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .gnt     (gnt_o[g]),
            .sel1    (sel1_o[g]),
            .sel0    (sel0_o[g]),
            .valid   (valid_o[g]),
            .preempt (preempt_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_step();
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                m_owner[g] = -1; m_held[g] = 0; m_last[g] = 3; m_sel[g] = 0; m_pre[g] = 0;
            end else begin
                bit release_now;
                int w;
                m_pre[g] = 0;
                release_now = 0;
                if (m_owner[g] < 0) release_now = 1;
                else if (!req[m_owner[g]]) release_now = 1;
                else if (m_held[g] >= HOLDS[g]) begin release_now = 1; m_pre[g] = 1; end
                else m_held[g]++;
                if (release_now) begin
                    w = pick(m_last[g], req);
                    m_owner[g] = w;
                    if (w >= 0) begin
                        m_last[g] = w; m_held[g] = 1; m_sel[g] = w;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NDUT; g++) begin
            int eg;
            eg = (m_owner[g] < 0) ? 0 : (1 << m_owner[g]);
            chk($sformatf("gnt_h%0d", HOLDS[g]), 32'(gnt_o[g]), eg);
            chk($sformatf("sel_h%0d", HOLDS[g]), 32'({sel1_o[g], sel0_o[g]}), m_sel[g]);
            chk($sformatf("valid_h%0d", HOLDS[g]), 32'(valid_o[g]), (m_owner[g] >= 0) ? 1 : 0);
            chk($sformatf("preempt_h%0d", HOLDS[g]), 32'(preempt_o[g]), m_pre[g]);
            chk($sformatf("onehot_h%0d", HOLDS[g]), 32'($onehot0(gnt_o[g])), 1);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input int n);
        for (int i = 0; i < n; i++) begin
            rst = r;
            req = q;
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;

        // reset with all requests pending, then requester 0 wins first
        step(1'b1, 4'b1111, 2);
        chk("rst_gnt", 32'(gnt_o[0]), 0);
        chk("rst_valid", 32'(valid_o[0]), 0);
        step(1'b0, 4'b1111, 1);
        chk("first_gnt", 32'(gnt_o[0]), 1);
        chk("first_gnt_h1", 32'(gnt_o[2]), 1);

        // single requester then drop
        step(1'b1, 4'b0000, 1);
        step(1'b0, 4'b0100, 3);
        step(1'b0, 4'b0000, 3);
        chk("idle_sel_hold", 32'({sel1_o[0], sel0_o[0]}), 2);

        // saturation
        step(1'b0, 4'b1111, 24);

        // back-to-back handoff 0 -> 3
        step(1'b0, 4'b0000, 2);
        step(1'b0, 4'b0001, 2);
        step(1'b0, 4'b1001, 1);
        step(1'b0, 4'b1000, 3);

        // reset mid-grant
        step(1'b0, 4'b0000, 1);
        step(1'b0, 4'b0100, 3);
        step(1'b1, 4'b1111, 1);
        step(1'b0, 4'b1111, 4);

        // preempted sole requester
        step(1'b0, 4'b0000, 1);
        step(1'b0, 4'b0010, 9);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) == 0), 4'($urandom), $urandom_range(1, 6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux datapath among four requesters. It grants at most one requester at a time and drives the mux select lines (sel1, sel0) to route the granted input. A hold-time limit stops any requester from monopolising the path. It sits directly in front of the 4:1 mux and owns its select inputs.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant; legal range 1..255 (0 is illegal).
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; req[i] is held high for as long as requester i wants the mux
gnt  output 4  one-hot registered grant; all-zero when idle
sel1 output 1  mux select MSB = granted index bit 1
sel0 output 1  mux select LSB = granted index bit 0
valid output 1  high while any grant is active; mux output is meaningful only when valid=1
preempt output 1  one-cycle pulse on the cycle a grant is revoked because MAX_HOLD expired

Behaviour:
- Reset (rst=1 at a clock edge): gnt=0000, sel1=0, sel0=0, valid=0, preempt=0, hold counter=0, state=IDLE, last-owner pointer=3, so requester 0 has top priority first. rst overrides all other inputs, including mid-grant.
- States: IDLE and GRANT.
- Priority search: scan from the index after the last-owner pointer upward, wrapping modulo 4 (for example, last=1 gives order 2,3,0,1). Pick the first index with req=1.
- IDLE:
  - If req != 0, next edge: gnt=onehot(winner), {sel1,sel0}=winner, valid=1, counter=1, state=GRANT, last=winner.
  - Latency from request to grant is 1 cycle.
  - If req == 0, remain in IDLE.
- GRANT, owner o, while req[o]=1 and counter < MAX_HOLD: hold gnt and sel; counter increments by 1 each cycle.
- Release on normal drop: req[o]=0 sampled → release on that edge.
- Release on expiry: counter == MAX_HOLD while req[o]=1 → release with preempt=1 for exactly the following cycle.
- On release, re-arbitrate in the same edge (no bubble cycle):
  - The search uses last=o, so the released owner is lowest priority.
  - A preempted owner that still requests is re-granted only if no other request is pending.
  - If a winner exists: grant it, counter=1, state stays GRANT.
  - If no winner: gnt=0000, valid=0, state=IDLE.
- Grant duration: a continuously held grant lasts exactly MAX_HOLD cycles. With MAX_HOLD=1, grants rotate every cycle.
- Select outputs:
  - sel1/sel0 always equal the granted index while valid=1.
  - In IDLE they hold their last value; they return to 00 only on reset.
- gnt is always one-hot or zero. A request arriving for a non-owner never disturbs the current grant.
- Registers: all outputs are registered; no combinational path from req to any output.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=1111 → gnt=0000, valid=0, {sel1,sel0}=00, preempt=0. After rst=0, the next edge gives gnt=0001, sel=00.
2. Single requester: req=0100 held 3 cycles, then 0000 → gnt=0100 and sel=10 one cycle after req rises, held 3 cycles, then gnt=0000 and valid=0. preempt never pulses.
3. Saturation, MAX_HOLD=4, req=1111 constant → gnt sequence 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles. preempt pulses once per handoff. valid is never 0.
4. Back-to-back handoff: requester 0 granted, req[3] rises, then req[0] drops at cycle k → gnt=1000 and sel=11 at edge k+1 with no idle cycle. preempt=0.
5. Reset mid-grant: requester 2 granted with counter=3, rst=1 for one edge → all outputs cleared next cycle. With req=1111 afterwards, the first grant goes to requester 0.
6. Preempted sole requester: MAX_HOLD=2, only req[1]=1 → gnt=0010 continuously. preempt pulses every 2 cycles, with no gap in valid.
